instruction_fetch_queue: RTL

//  Fetch stage ahead of the IF/ID register. Issues sequential requests to a variable-latency

---
 rtl/mips_defs.sv | 23 ++
 rtl/ifq_fifo.sv | 75 +++++++
 rtl/instruction_fetch_queue.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mips_defs.sv
// -----------------------------------------------------------------------------
// mips_defs
//   Shared definitions for the fetch stage.
//   - fetch_state_e : fetch FSM encoding (FETCH, DROP)
//   - NOP_INSTR     : instruction presented when no valid entry is at the head
//   - WORD_BYTES    : fetch stride in bytes
//   - word_align()  : clears the two byte-offset bits of an address
// -----------------------------------------------------------------------------
package mips_defs;

    typedef enum logic [0:0] {
        FETCH = 1'b0,  // issuing sequential requests while the queue has room
        DROP  = 1'b1   // waiting out a stale request after a redirect
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// -----------------------------------------------------------------------------
// ifq_fifo
//   DEPTH x 64-bit circular buffer holding {instruction, pc_plus4} entries.
//   Ports:
//     clk_i, rst_i  : clock, asynchronous active-high reset
//     clear_i       : empties the buffer; wins over push/pop in the same cycle
//     push_i        : write push_data_i at the tail
//     push_data_i   : 64-bit entry
//     pop_i         : retire the head entry
//     head_o        : entry at the head (undefined content when count_o == 0)
//     count_o       : number of valid entries, 0..DEPTH
//   The caller never pops an empty buffer or pushes into a full one unless it
//   also pops in that cycle; pointers wrap naturally because DEPTH is 2^n.
// -----------------------------------------------------------------------------
module ifq_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clear_i,
    input  logic                         push_i,
    input  logic [63:0]                  push_data_i,
    input  logic                         pop_i,
    output logic [63:0]                  head_o,
    output logic [$clog2(DEPTH):0]       count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing reads it while count is zero.
    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_queue.sv
// -----------------------------------------------------------------------------
// instruction_fetch_queue
//   Fetch stage in front of the IF/ID register. Issues one sequential request
//   at a time to a variable-latency instruction memory and queues the returned
//   words with their PC+4. Redirects from MEM flush the queue and restart
//   fetching at the new address; a request still in flight at that moment is
//   completed and its data thrown away (DROP state).
//   Ports:
//     Clk, Reset             : clock, asynchronous active-high reset
//     Redirect, RedirectPC   : taken branch/jump; RedirectPC[1:0] are ignored
//     Stall                  : consumer not accepting this cycle
//     ImemReq, ImemAddr      : request valid / word address; both hold until ack
//     ImemAck, ImemData      : completes the current request with its word
//     InstValid, Instruction : head entry valid / head word (NOP when empty)
//     PCPlus4                : head entry address + 4 (0 when empty)
//     StallCycles, EmptyCycles, FlushCount : saturating performance counters
//   Handshake: a request is outstanding from the cycle ImemReq is high until
//   the first cycle with ImemReq && ImemAck (possibly the same cycle); ImemReq
//   and ImemAddr do not change while a request is outstanding.
//   Configuration macro: IFQ_PERF_COUNTERS_EN enables the counters; without it
//   the counter outputs are constant 0.
// -----------------------------------------------------------------------------
module instruction_fetch_queue
    import mips_defs::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    input  logic        Stall,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemData,
    output logic        InstValid,
    output logic [31:0] Instruction,
    output logic [31:0] PCPlus4,
    output logic [31:0] StallCycles,
    output logic [31:0] EmptyCycles,
    output logic [31:0] FlushCount
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   drop_addr_q, drop_addr_d;
    logic          req_q, req_d;

    logic          ack_v;
    logic          push, pop;
    logic [CW-1:0] count, count_next;
    logic [63:0]   head;

    ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i       (Clk),
        .rst_i       (Reset),
        .clear_i     (Redirect),
        .push_i      (push),
        .push_data_i ({ImemData, fetch_pc_q + WORD_BYTES}),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count)
    );

    assign InstValid = (count != '0);
    assign ack_v     = req_q && ImemAck;
    // Redirect voids both the word arriving this cycle and any dequeue.
    assign push      = (state_q == FETCH) && ack_v && !Redirect;
    assign pop       = InstValid && !Stall && !Redirect;

    always_comb begin
        count_next = count;
        if (Redirect) begin
            count_next = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_next = count + CW'(1);
                2'b01:   count_next = count - CW'(1);
                default: count_next = count;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        drop_addr_d = drop_addr_q;
        case (state_q)
            FETCH: begin
                if (Redirect) begin
                    fetch_pc_d = word_align(RedirectPC);
                    // Request in flight and not finishing now: wait it out.
                    if (req_q && !ImemAck) begin
                        state_d     = DROP;
                        drop_addr_d = fetch_pc_q;
                    end
                end else if (ack_v) begin
                    fetch_pc_d = fetch_pc_q + WORD_BYTES;
                end
            end
            DROP: begin
                if (Redirect) fetch_pc_d = word_align(RedirectPC);
                if (ImemAck)  state_d    = FETCH;
            end
            default: state_d = FETCH;
        endcase
        // A new request is only raised when the entry it returns is
        // guaranteed a free slot; once raised it stays up until its ack since
        // the count can only fall meanwhile.
        req_d = (state_d == DROP) || (count_next < DEPTH_C);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= FETCH;
            fetch_pc_q  <= RESET_PC;
            drop_addr_q <= '0;
            req_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            drop_addr_q <= drop_addr_d;
            req_q       <= req_d;
        end
    end

    assign ImemReq     = req_q;
    assign ImemAddr    = (state_q == DROP) ? drop_addr_q : fetch_pc_q;
    assign Instruction = InstValid ? head[63:32] : NOP_INSTR;
    assign PCPlus4     = InstValid ? head[31:0]  : 32'h0;

`ifdef IFQ_PERF_COUNTERS_EN
    logic [31:0] stall_cycles_q, empty_cycles_q, flush_count_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stall_cycles_q <= '0;
            empty_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (InstValid && Stall && (stall_cycles_q != '1))
                stall_cycles_q <= stall_cycles_q + 32'd1;
            if (!InstValid && !Redirect && (empty_cycles_q != '1))
                empty_cycles_q <= empty_cycles_q + 32'd1;
            if (Redirect && (flush_count_q != '1))
                flush_count_q <= flush_count_q + 32'd1;
        end
    end

    assign StallCycles = stall_cycles_q;
    assign EmptyCycles = empty_cycles_q;
    assign FlushCount  = flush_count_q;
`else
    assign StallCycles = 32'h0;
    assign EmptyCycles = 32'h0;
    assign FlushCount  = 32'h0;
`endif

endmodule
